// File: rtl/bits_stream_if.sv
// bits_stream_if: word input and serialized output bundle for bits_stream.
// The producer side uses master, the serializer uses slave.
interface bits_stream_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   logic [WIDTH-1:0]       in_data;
   logic                   in_nd;
   logic [WIDTH-1:0]       out_data;
   logic                   out_nd;
   logic                   error;
   logic [$clog2(DEPTH):0] fifo_level;

   modport master (
      output in_data,
      output in_nd,
      input  out_data,
      input  out_nd,
      input  error,
      input  fifo_level
   );

   modport slave (
      input  in_data,
      input  in_nd,
      output out_data,
      output out_nd,
      output error,
      output fifo_level
   );
endinterface

// File: rtl/bits_stream.sv
// bits_stream: buffers WIDTH-bit words in a DEPTH-entry FIFO and emits each as (position, chunk)
// pairs, LSB chunk first. Define BITS_STREAM_SKIP_ZERO_EN to suppress all-zero chunks.
module bits_stream #(
   parameter int          WIDTH     = 32,
   parameter int          CHUNK     = 1,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] ERRORCODE = 32'hDEADBEEF
) (
   input  logic         clk,
   input  logic         reset,
   bits_stream_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = $clog2(NCHUNK) + 1;
   localparam int AW     = $clog2(DEPTH);
   localparam int LW     = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, POS, VAL, ERR} state_t;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic [WIDTH-1:0] r_work;
   logic [KW-1:0]    r_k;
   state_t           r_state;
   logic             r_pending;
   logic             r_error;
   logic             r_out_nd;
   logic [WIDTH-1:0] r_out_data;

   logic             w_last;
   logic             w_skip_cur;
   logic             w_show_first;
   logic             w_show_next;
   logic             w_word_end;
   logic             w_between;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [CHUNK-1:0] w_cur_chunk;

   assign w_last      = (r_k == KW'(NCHUNK - 1));
   assign w_cur_chunk = CHUNK'(r_work >> (CHUNK * 32'(r_k)));

`ifdef BITS_STREAM_SKIP_ZERO_EN
   // Zero chunks are decided one cycle ahead because out_nd is registered.
   assign w_skip_cur   = (w_cur_chunk == '0);
   assign w_show_first = |r_mem[r_rd_ptr][CHUNK-1:0];
   assign w_show_next  = |CHUNK'(r_work >> (CHUNK * (32'(r_k) + 32'd1)));
`else
   assign w_skip_cur   = 1'b0;
   assign w_show_first = 1'b1;
   assign w_show_next  = 1'b1;
`endif

   assign w_word_end = w_last && ((r_state == VAL) || ((r_state == POS) && w_skip_cur));
   assign w_between  = (r_state == IDLE) || (r_state == ERR) || w_word_end;
   assign w_pop      = w_between && !r_pending && (r_level != '0);
   assign w_push     = bus.in_nd && ((r_level != LW'(DEPTH)) || w_pop);
   assign w_drop     = bus.in_nd && !w_push;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // The state register names what out_data shows this cycle; outputs are loaded on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_k        <= '0;
         r_work     <= '0;
         r_pending  <= 1'b0;
         r_error    <= 1'b0;
         r_out_nd   <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_out_nd <= 1'b0;
         if (w_between) begin
            if (w_pop) begin
               r_state <= POS;
               r_k     <= '0;
               r_work  <= r_mem[r_rd_ptr];
               if (w_show_first) begin
                  r_out_data <= '0;
                  r_out_nd   <= 1'b1;
               end
            end else if (r_pending && !w_word_end) begin
               r_state    <= ERR;
               r_pending  <= 1'b0;
               r_out_data <= WIDTH'(ERRORCODE);
               r_out_nd   <= 1'b1;
            end else begin
               r_state <= IDLE;
            end
         end else begin
            case (r_state)
               POS: begin
                  if (w_skip_cur) begin
                     r_k <= r_k + KW'(1);
                     if (w_show_next) begin
                        r_out_data <= WIDTH'(r_k + KW'(1));
                        r_out_nd   <= 1'b1;
                     end
                  end else begin
                     r_state    <= VAL;
                     r_out_data <= WIDTH'(w_cur_chunk);
                     r_out_nd   <= 1'b1;
                  end
               end
               VAL: begin
                  r_state <= POS;
                  r_k     <= r_k + KW'(1);
                  if (w_show_next) begin
                     r_out_data <= WIDTH'(r_k + KW'(1));
                     r_out_nd   <= 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
         // A drop in the same cycle as entering ERR still earns its own marker.
         if (w_drop) begin
            r_pending <= 1'b1;
            r_error   <= 1'b1;
         end
      end
   end

   assign bus.out_data   = r_out_data;
   assign bus.out_nd     = r_out_nd;
   assign bus.error      = r_error;
   assign bus.fifo_level = r_level;
endmodule
